// File: rtl/fpga_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpga_spi_pkg
// Purpose  : Register map, status/control bit positions and frame width shared
//            by the FPGA SPI slave and the SPI master.
// Revision : 1.0
// ============================================================================
package fpga_spi_pkg;

    localparam int FRAME_BITS = 8;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

    typedef enum logic [2:0] {
        REG_RXDATA  = 3'd0,
        REG_TXDATA  = 3'd1,
        REG_STATUS  = 3'd2,
        REG_CONTROL = 3'd3
    } spi_reg_e;

    localparam int STAT_ROE  = 3;
    localparam int STAT_TOE  = 4;
    localparam int STAT_TRDY = 6;
    localparam int STAT_RRDY = 7;
    localparam int STAT_E    = 8;
    localparam int STAT_ACT  = 9;

    // Control bits that can gate a status flag onto irq: E, RRDY, TRDY, TOE, ROE.
    localparam logic [15:0] IRQ_EN_MASK = 16'h01D8;

    typedef struct packed {
        logic act;
        logic rrdy;
        logic trdy;
        logic toe;
        logic roe;
    } spi_flags_t;

    function automatic logic [15:0] pack_status(input spi_flags_t f);
        logic [15:0] s;
        s            = '0;
        s[STAT_ACT]  = f.act;
        s[STAT_E]    = f.roe | f.toe;
        s[STAT_RRDY] = f.rrdy;
        s[STAT_TRDY] = f.trdy;
        s[STAT_TOE]  = f.toe;
        s[STAT_ROE]  = f.roe;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_sync
// Purpose  : Multi-flop synchronizer for one asynchronous SPI line; exposes the
//            last two stages so the parent can detect edges.
// Revision : 1.0
// ============================================================================
module spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic q_prev
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    // q is the older sample, q_prev the newer one: q_prev != q marks an edge.
    assign q      = chain[STAGES-1];
    assign q_prev = chain[STAGES-2];

endmodule
`default_nettype wire

// File: rtl/fpga_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : fpga_spi_slave
// Purpose  : Mode-0, 8-bit, MSB-first SPI slave with a CPU register interface
//            (rxdata, txdata, status, control) and a maskable interrupt.
// Revision : 1.0
// ============================================================================
module fpga_spi_slave
    import fpga_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        spi_select,
    input  logic [2:0]  mem_addr,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    output logic        irq,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe
);

    logic sclk_s, sclk_p;
    logic ss_s, ss_p;
    logic mosi_s, mosi_prev_unused;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (SCLK),
        .q      (sclk_s),
        .q_prev (sclk_p)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (SS_n),
        .q      (ss_s),
        .q_prev (ss_p)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (MOSI),
        .q      (mosi_s),
        .q_prev (mosi_prev_unused)
    );

    logic selected, ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign selected  = ~ss_s;
    assign ss_fall   = ss_s & ~ss_p;
    assign ss_rise   = ~ss_s & ss_p;
    assign sclk_rise = selected & sclk_p & ~sclk_s;
    assign sclk_fall = selected & ~sclk_p & sclk_s;

    // ------------------------------------------------------------------
    // CPU access strobes: one-cycle pulse per two-cycle access
    // ------------------------------------------------------------------
    logic rd_strobe, rd_strobe_q, wr_strobe, wr_strobe_q;
    logic rx_read, tx_write, stat_write, ctrl_write;

    assign rd_strobe  = ~rd_strobe_q & spi_select & ~read_n;
    assign wr_strobe  = ~wr_strobe_q & spi_select & ~write_n;
    assign rx_read    = rd_strobe & (mem_addr == REG_RXDATA);
    assign tx_write   = wr_strobe & (mem_addr == REG_TXDATA);
    assign stat_write = wr_strobe & (mem_addr == REG_STATUS);
    assign ctrl_write = wr_strobe & (mem_addr == REG_CONTROL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_strobe_q <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            rd_strobe_q <= rd_strobe;
            wr_strobe_q <= wr_strobe;
        end
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  byte_done;
    logic [FRAME_BITS-1:0] rx_shift, rx_holding, rx_next;
    logic [FRAME_BITS-1:0] tx_shift, tx_holding;
    logic                  rrdy, roe, toe, trdy;
    logic                  byte_complete, reload;

    assign rx_next       = {rx_shift[FRAME_BITS-2:0], mosi_s};
    assign byte_complete = sclk_rise & (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    // Shift register is (re)primed at frame start and on the falling edge
    // that closes a byte, so a continuous SS_n can stream frames.
    assign reload        = ss_fall | (sclk_fall & byte_done);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt    <= '0;
            byte_done  <= 1'b0;
            rx_shift   <= '0;
            rx_holding <= '0;
            tx_shift   <= '0;
        end else begin
            if (sclk_rise) begin
                rx_shift <= rx_next;
                if (byte_complete) begin
                    rx_holding <= rx_next;
                    bit_cnt    <= '0;
                    byte_done  <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                end
            end
            if (reload) begin
                tx_shift  <= trdy ? '0 : tx_holding;
                byte_done <= 1'b0;
            end else if (sclk_fall) begin
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end
            if (ss_fall || ss_rise) begin
                bit_cnt   <= '0;
                byte_done <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status flags and transmit holding register; later assignments win
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rrdy       <= 1'b0;
            roe        <= 1'b0;
            toe        <= 1'b0;
            trdy       <= 1'b1;
            tx_holding <= '0;
        end else begin
            if (stat_write) begin
                rrdy <= 1'b0;
                roe  <= 1'b0;
                toe  <= 1'b0;
            end
            if (rx_read) begin
                rrdy <= 1'b0;
            end
            if (reload) begin
                if (trdy) begin
                    toe <= 1'b1;
                end else begin
                    trdy <= 1'b1;
                end
            end
            if (tx_write) begin
                if (trdy) begin
                    tx_holding <= data_from_cpu[FRAME_BITS-1:0];
                    trdy       <= 1'b0;
                end else begin
                    toe <= 1'b1;
                end
            end
            if (byte_complete) begin
                rrdy <= 1'b1;
                if (rrdy && !rx_read) begin
                    roe <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file, read port and interrupt
    // ------------------------------------------------------------------
    logic [15:0] control;
    logic [15:0] status_word;
    logic [15:0] read_word;
    spi_flags_t  flags;

    assign flags       = '{act: selected, rrdy: rrdy, trdy: trdy, toe: toe, roe: roe};
    assign status_word = pack_status(flags);

    always_comb begin
        read_word = '0;
        case (mem_addr)
            REG_RXDATA:  read_word = 16'(rx_holding);
            REG_STATUS:  read_word = status_word;
            REG_CONTROL: read_word = control;
            default:     read_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            control     <= '0;
            data_to_cpu <= '0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_write) begin
                control <= data_from_cpu;
            end
            if (rd_strobe) begin
                data_to_cpu <= read_word;
            end
            irq <= |(status_word & control & IRQ_EN_MASK);
        end
    end

    assign MISO    = selected ? tx_shift[FRAME_BITS-1] : 1'b0;
    assign MISO_oe = selected;

endmodule
`default_nettype wire
